// File: rtl/voltmeter_pkg.sv
// Shared voltmeter definitions: AFE phase encodings used by the measurement FSM
// and the capture block, default counter width and the capture state encoding.
package voltmeter_pkg;

    localparam logic [1:0] AFE_IDLE        = 2'b00;
    localparam logic [1:0] AFE_AUTO_ZERO   = 2'b01;
    localparam logic [1:0] AFE_INTEGRATE   = 2'b10;
    localparam logic [1:0] AFE_DEINTEGRATE = 2'b11;

    localparam int CNT_W_DEFAULT = 16;

    typedef enum logic [1:0] {
        CAP_IDLE      = 2'b00,
        CAP_COUNT     = 2'b01,
        CAP_DONE      = 2'b10,
        CAP_WAIT_EXIT = 2'b11
    } capture_state_e;

endpackage

// File: rtl/deint_result_capture_if.sv
// Result path from the deintegrate capture block to the readout/display logic.
interface deint_result_capture_if #(
    parameter int CNT_W = voltmeter_pkg::CNT_W_DEFAULT
);
    logic [CNT_W-1:0] result_mag;
    logic             result_neg;
    logic             overrange;
    logic             overrun;
    logic             result_valid;
    logic             result_ready;

    // A result transfers on a clock edge with result_valid and result_ready both
    // high; while result_valid is high and not accepted, the fields hold steady
    // unless a newer capture overwrites them (which raises overrun).
    modport master (
        output result_mag, result_neg, overrange, overrun, result_valid,
        input  result_ready
    );

    modport slave (
        input  result_mag, result_neg, overrange, overrun, result_valid,
        output result_ready
    );
endinterface

// File: rtl/sync_ff.sv
// Multi-stage bit synchroniser for an asynchronous input, synchronous active-low reset.
module sync_ff #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d,
    output logic q
);
    logic [SYNC_STAGES-1:0] chain;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            chain <= '0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], d};
        end
    end

    assign q = chain[SYNC_STAGES-1];
endmodule

// File: rtl/deint_result_capture.sv
// Times the deintegrate phase until the comparator crosses, pulses done back to the
// measurement FSM and holds a sign-magnitude result for the readout handshake.
module deint_result_capture
    import voltmeter_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEFAULT,
    parameter int MAX_COUNT   = 512,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [1:0]            afe_sel_i,
    input  logic                  ref_sign_i,
    input  logic                  comp_i,
    output logic                  deint_done_o,
    output logic                  busy_o,
    output capture_state_e        state_o,
    deint_result_capture_if.master res
);
    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(MAX_COUNT - 1);
    localparam logic [CNT_W-1:0] OVR_MAG   = CNT_W'(MAX_COUNT);
    localparam logic [CNT_W-1:0] SYNC_LAT  = CNT_W'(SYNC_STAGES - 1);

    capture_state_e   state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pol_q, pol_d;
    logic             sign_q, sign_d;
    logic             comp_s;
    logic             capture;
    logic [CNT_W-1:0] cap_mag;
    logic             cap_ovr;
    logic             cap_neg;

    logic [CNT_W-1:0] mag_q;
    logic             neg_q, ovr_q, overrun_q, valid_q;

    sync_ff #(.SYNC_STAGES(SYNC_STAGES)) u_comp_sync (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d      (comp_i),
        .q      (comp_s)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= CAP_IDLE;
            cnt_q   <= '0;
            pol_q   <= 1'b0;
            sign_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pol_q   <= pol_d;
            sign_q  <= sign_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pol_d   = pol_q;
        sign_d  = sign_q;
        capture = 1'b0;
        cap_mag = '0;
        cap_ovr = 1'b0;
        case (state_q)
            CAP_IDLE: begin
                if (afe_sel_i == AFE_DEINTEGRATE) begin
                    state_d = CAP_COUNT;
                    cnt_d   = '0;
                    pol_d   = comp_s;
                    sign_d  = ~ref_sign_i;
                end
            end
            CAP_COUNT: begin
                if (afe_sel_i != AFE_DEINTEGRATE) begin
                    state_d = CAP_IDLE;
                end else if (comp_s != pol_q) begin
                    // Remove the synchroniser delay so the magnitude is the edge
                    // at which comp_i was first sampled changed.
                    capture = 1'b1;
                    cap_mag = (cnt_q >= SYNC_LAT) ? cnt_q - SYNC_LAT : '0;
                    state_d = CAP_DONE;
                end else if (cnt_q == LAST_CNT) begin
                    capture = 1'b1;
                    cap_mag = OVR_MAG;
                    cap_ovr = 1'b1;
                    state_d = CAP_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            CAP_DONE: begin
                state_d = CAP_WAIT_EXIT;
            end
            CAP_WAIT_EXIT: begin
                if (afe_sel_i != AFE_DEINTEGRATE) begin
                    state_d = CAP_IDLE;
                end
            end
            default: begin
                state_d = CAP_IDLE;
            end
        endcase
    end

    assign cap_neg = sign_q & (cap_mag != '0);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            mag_q     <= '0;
            neg_q     <= 1'b0;
            ovr_q     <= 1'b0;
            overrun_q <= 1'b0;
            valid_q   <= 1'b0;
        end else if (capture) begin
            mag_q     <= cap_mag;
            neg_q     <= cap_neg;
            ovr_q     <= cap_ovr;
            valid_q   <= 1'b1;
            // Only an unaccepted result counts as lost; a same-edge accept clears it.
            overrun_q <= valid_q & ~res.result_ready;
        end else if (valid_q && res.result_ready) begin
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end
    end

    assign deint_done_o     = (state_q == CAP_DONE);
    assign busy_o           = (state_q == CAP_COUNT);
    assign state_o          = state_q;
    assign res.result_mag   = mag_q;
    assign res.result_neg   = neg_q;
    assign res.overrange    = ovr_q;
    assign res.overrun      = overrun_q;
    assign res.result_valid = valid_q;
endmodule

// File: tb/tb_deint_result_capture.sv
// Directed bench for deint_result_capture with an expected-result queue.
module tb_deint_result_capture;
    import voltmeter_pkg::*;

    localparam int CNT_W       = 16;
    localparam int MAX_COUNT   = 512;
    localparam int SYNC_STAGES = 2;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [1:0]     afe_sel = AFE_IDLE;
    logic           ref_sign = 1'b0;
    logic           comp = 1'b0;
    logic           done;
    logic           busy;
    capture_state_e state;

    deint_result_capture_if #(.CNT_W(CNT_W)) res_if ();

    deint_result_capture #(
        .CNT_W       (CNT_W),
        .MAX_COUNT   (MAX_COUNT),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .afe_sel_i    (afe_sel),
        .ref_sign_i   (ref_sign),
        .comp_i       (comp),
        .deint_done_o (done),
        .busy_o       (busy),
        .state_o      (state),
        .res          (res_if)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [CNT_W+1:0] exp_q[$];
    logic exp_valid = 1'b0;
    logic exp_overrun = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_flags"}, {26'd0, done, busy, res_if.result_neg, res_if.overrange,
                              res_if.overrun, res_if.result_valid}, 32'd0);
        chk({tag, "_mag"}, res_if.result_mag, 0);
        chk({tag, "_state"}, state, CAP_IDLE);
    endtask

    task automatic convert(input int n, input logic rs, input logic tog, input logic rdy_cap);
        int lat;
        int want_lat;
        logic [CNT_W-1:0] m;
        logic [CNT_W+1:0] e;
        logic rdy_at_cap;
        m = tog ? CNT_W'(n) : CNT_W'(MAX_COUNT);
        exp_q.push_back({~tog, (m != '0) & ~rs, m});
        afe_sel = AFE_DEINTEGRATE;
        ref_sign = rs;
        if (tog) begin
            repeat (n) @(negedge clk);
            comp = ~comp;
            want_lat = SYNC_STAGES + 1;
        end else begin
            want_lat = MAX_COUNT + 1;
        end
        lat = 0;
        while (done !== 1'b1 && lat < 2000) begin
            if (rdy_cap && lat == SYNC_STAGES) res_if.result_ready = 1'b1;
            @(negedge clk);
            lat++;
            if (lat == 1) chk("busy_counting", busy, 1);
        end
        if (done !== 1'b1) begin
            chk("done_timeout", 0, 1);
            res_if.result_ready = 1'b0;
            void'(exp_q.pop_front());
            return;
        end
        chk("done_latency", lat, want_lat);
        rdy_at_cap = res_if.result_ready;
        if (rdy_at_cap) exp_overrun = 1'b0;
        else if (exp_valid) exp_overrun = 1'b1;
        exp_valid = 1'b1;
        res_if.result_ready = 1'b0;
        e = exp_q.pop_front();
        chk("result_ovr_neg_mag", {res_if.overrange, res_if.result_neg, res_if.result_mag}, e);
        chk("valid_at_done", res_if.result_valid, exp_valid);
        chk("overrun_at_done", res_if.overrun, exp_overrun);
        chk("busy_at_done", busy, 0);
        @(negedge clk);
        chk("done_one_cycle", done, 0);
        chk("state_wait_exit", state, CAP_WAIT_EXIT);
    endtask

    task automatic exit_phase();
        afe_sel = AFE_IDLE;
        @(negedge clk);
        chk("state_idle_after_exit", state, CAP_IDLE);
        idle(3);
    endtask

    task automatic accept();
        res_if.result_ready = 1'b1;
        @(negedge clk);
        res_if.result_ready = 1'b0;
        exp_valid = 1'b0;
        exp_overrun = 1'b0;
        chk("valid_after_accept", res_if.result_valid, exp_valid);
        chk("overrun_after_accept", res_if.overrun, exp_overrun);
    endtask

    initial begin
        int dones;
        res_if.result_ready = 1'b0;
        idle(3);
        chk_all_zero("reset");
        rst_n = 1'b1;
        idle(4);

        // Plain conversion, positive input, result held until accepted.
        convert(100, 1'b1, 1'b1, 1'b0);
        exit_phase();
        idle(5);
        chk("valid_held", res_if.result_valid, 1);
        chk("mag_held", res_if.result_mag, 100);

        // Reset in the middle of a count discards everything, including the held result.
        afe_sel = AFE_DEINTEGRATE;
        ref_sign = 1'b0;
        repeat (41) @(negedge clk);
        chk("busy_before_reset", busy, 1);
        rst_n = 1'b0;
        afe_sel = AFE_IDLE;
        @(negedge clk);
        chk_all_zero("midcount_reset");
        exp_valid = 1'b0;
        exp_overrun = 1'b0;
        exp_q.delete();
        rst_n = 1'b1;
        idle(4);
        convert(100, 1'b1, 1'b1, 1'b0);
        exit_phase();
        accept();

        // No crossing: overrange at the count limit.
        convert(0, 1'b0, 1'b0, 1'b0);
        exit_phase();

        // Abort mid-count leaves the held overrange result alone.
        afe_sel = AFE_DEINTEGRATE;
        repeat (31) @(negedge clk);
        chk("busy_before_abort", busy, 1);
        afe_sel = AFE_IDLE;
        dones = 0;
        repeat (5) begin
            @(negedge clk);
            if (done) dones++;
        end
        chk("abort_no_done", dones, 0);
        chk("abort_busy", busy, 0);
        chk("abort_state", state, CAP_IDLE);
        chk("abort_valid_kept", res_if.result_valid, 1);
        chk("abort_mag_kept", res_if.result_mag, MAX_COUNT);
        chk("abort_ovr_kept", res_if.overrange, 1);
        accept();

        // Overwrite of an unread result, then same-edge accept and capture.
        convert(100, 1'b1, 1'b1, 1'b0);
        exit_phase();
        convert(57, 1'b0, 1'b1, 1'b0);
        exit_phase();
        accept();
        convert(80, 1'b1, 1'b1, 1'b0);
        exit_phase();
        convert(33, 1'b0, 1'b1, 1'b1);
        exit_phase();
        accept();

        // Crossing already present at entry: zero magnitude, sign forced positive,
        // and no re-arm while the deintegrate phase is held.
        convert(0, 1'b0, 1'b1, 1'b0);
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            if (i == 3 || i == 7) comp = ~comp;
            @(negedge clk);
            if (done) dones++;
        end
        chk("hold_no_rearm", dones, 0);
        chk("hold_state", state, CAP_WAIT_EXIT);
        chk("hold_mag", res_if.result_mag, 0);
        exit_phase();
        convert(20, 1'b1, 1'b1, 1'b0);
        exit_phase();
        chk("queue_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/deint_result_capture.md
Name: deint_result_capture

Overview:
- Downstream of the measurement FSM; consumes its AFE phase select and reference sign plus the analog comparator.
- Measures deintegrate duration in clock cycles, detects the comparator zero-crossing and returns a one-cycle done pulse to the FSM.
- Latches a sign-magnitude conversion result and presents it to the readout/display logic through a valid/ready handshake.

Parameters:
CNT_W, 16, width of the deintegrate counter and result magnitude
MAX_COUNT, 512, deintegrate cycle limit; reaching it without a crossing is overrange (must be < 2^CNT_W)
SYNC_STAGES, 2, comparator synchroniser depth (>=2)

Ports:
clk_i  input  1  system clock
rst_ni  input  1  synchronous active-low reset
afe_sel_i  input  2  AFE phase from FSM: 00 idle, 01 auto-zero, 10 integrate, 11 deintegrate
ref_sign_i  input  1  reference polarity applied during deintegrate (1 = negative ref, i.e. positive input)
comp_i  input  1  asynchronous integrator comparator output
deint_done_o  output  1  one-cycle pulse: crossing detected or overrange
busy_o  output  1  high while counting a deintegrate phase
result_mag_o  output  CNT_W  captured magnitude
result_neg_o  output  1  1 = negative input voltage
overrange_o  output  1  captured result hit MAX_COUNT
overrun_o  output  1  sticky: an unread result was overwritten
result_valid_o  output  1  result fields valid
result_ready_i  input  1  consumer accepts result

Behaviour:
- Reset (rst_ni low at a clock edge): all outputs 0, counter 0, state IDLE, synchroniser flops 0. Reset takes priority at any point, including mid-count; a partial count is discarded.
- Comparator synchroniser: comp_i passes through SYNC_STAGES flops to give comp_s; only comp_s is used.
- States:
  - IDLE: on the edge where afe_sel_i==11, go to COUNT; cnt<=0; pol<=comp_s; sign<=~ref_sign_i; busy_o<=1.
  - COUNT, each edge:
    - If afe_sel_i!=11: abort. Go to IDLE, no done pulse, no result; existing result untouched.
    - Else if comp_s!=pol: crossing. Capture mag = cnt-(SYNC_STAGES-1), saturating at 0. Go to DONE.
    - Else if cnt==MAX_COUNT-1: overrange. Capture mag = MAX_COUNT, overrange flag = 1. Go to DONE.
    - Else cnt<=cnt+1.
  - DONE (one cycle): deint_done_o=1, busy_o=0. Result registers update, result_valid_o<=1. Then go to WAIT_EXIT.
  - WAIT_EXIT: hold until afe_sel_i!=11, then go to IDLE. This prevents re-arming in the same phase.
- Latency: if comp_i is first sampled changed at edge N after entry (entry edge = 0), result_mag_o = N. deint_done_o rises SYNC_STAGES edges after that sample.
- Handshake:
  - result_valid_o stays high until an edge with result_ready_i=1; it then clears.
  - Result fields hold stable while valid and not accepted.
- Overwrite: a new capture while result_valid_o=1 and not accepted overwrites the fields and sets overrun_o.
- Simultaneous accept and capture in the same cycle: the new result wins, valid stays 1, overrun_o not set.
- overrun_o clears on the next accepted handshake.
- Arithmetic: unsigned counter; no wrap is possible because MAX_COUNT < 2^CNT_W. result_neg_o is forced to 0 when mag==0.

Decomposition:
- Shared package voltmeter_pkg holds:
  - AFE_IDLE/AFE_AUTO_ZERO/AFE_INTEGRATE/AFE_DEINTEGRATE encodings, shared with the FSM.
  - Default CNT_W.
  - The capture state encoding.
- One sub-module, sync_ff (parameterised SYNC_STAGES bit synchroniser, synchronous active-low reset), instantiated for comp_i.

Test Plan:
1. Reset mid-COUNT (cnt=40) -> next edge all outputs 0. Then a full phase with crossing at edge 100 -> result_mag_o=100, no stale state.
2. afe_sel_i=11, ref_sign_i=1, comp_i toggles sampled at edge 100, result_ready_i=0 -> deint_done_o pulse 2 edges later, result_mag_o=100, result_neg_o=0, overrange_o=0, valid held until ready=1.
3. comp_i never toggles, MAX_COUNT=512 -> done pulse at count 511, result_mag_o=512, overrange_o=1, valid=1.
4. afe_sel_i drops to 00 at cnt=30 (FSM error abort) -> no done pulse, result_valid_o unchanged, returns IDLE, busy_o=0.
5. Two conversions (mags 100 then 57) with ready=0 -> second overwrites, overrun_o=1. Ready=1 one cycle -> valid=0, overrun_o=0. Repeat with ready=1 on the capture edge -> valid=1, overrun_o=0.
6. Crossing sampled at edge 0 (comp already flipped) -> result_mag_o=0, result_neg_o=0. afe_sel_i held 11 after done -> no second capture until afe_sel_i leaves 11.
